// File: rtl/wb_mem_model_mp.sv
// Multi-port Wishbone memory/MMIO model: instruction read, data read and data write
// ports over one shared byte array, with per-port latency, range errors, console and halt.
module wb_mem_model_mp #(
  parameter int          P_MEM_BYTES     = 262144,
  parameter int          P_INST_LATENCY  = 1,
  parameter int          P_READ_LATENCY  = 1,
  parameter int          P_WRITE_LATENCY = 1,
  parameter logic [31:0] P_CONSOLE_ADDR  = 32'h1000_0000,
  parameter logic [31:0] P_HALT_ADDR     = 32'h1000_0004,
  parameter string       P_INIT_FILE     = ""
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_inst_read_stb,
  output logic        o_inst_read_ack,
  output logic        o_inst_read_err,
  input  logic [31:0] i_inst_read_addr,
  output logic [31:0] o_inst_read_data,
  input  logic        i_master_read_stb,
  output logic        o_master_read_ack,
  output logic        o_master_read_err,
  input  logic [31:0] i_master_read_addr,
  output logic [31:0] o_master_read_data,
  input  logic        i_master_write_stb,
  output logic        o_master_write_ack,
  output logic        o_master_write_err,
  input  logic [31:0] i_master_write_addr,
  input  logic [31:0] i_master_write_data,
  input  logic [3:0]  i_master_write_sel,
  output logic        o_console_valid,
  output logic [7:0]  o_console_char,
  output logic        o_halt,
  output logic [31:0] o_halt_code
);

  localparam int          AW        = $clog2(P_MEM_BYTES);
  localparam logic [32:0] MEM_LIMIT = 33'(P_MEM_BYTES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} port_state_t;
  typedef enum logic [1:0] {AC_MEM, AC_CONSOLE, AC_HALT, AC_OOR} acc_kind_t;

  logic [7:0] mem [P_MEM_BYTES];

  // MMIO decode takes priority over the range check so MMIO never reports err.
  function automatic acc_kind_t classify(input logic [31:0] a);
    logic [31:0] eff;
    eff = a & ~32'h3;
    if (eff == P_CONSOLE_ADDR)      return AC_CONSOLE;
    if (eff == P_HALT_ADDR)         return AC_HALT;
    if ({1'b0, eff} >= MEM_LIMIT)   return AC_OOR;
    return AC_MEM;
  endfunction

  function automatic logic [AW-1:0] byte_idx(input logic [31:0] a, input int k);
    return AW'(a & ~32'h3) | AW'(k);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem[byte_idx(a, 3)], mem[byte_idx(a, 2)], mem[byte_idx(a, 1)], mem[byte_idx(a, 0)]};
  endfunction

  logic [1:0]       rd_stb;
  logic [1:0][31:0] rd_addr_in;
  assign rd_stb     = {i_master_read_stb, i_inst_read_stb};
  assign rd_addr_in = {i_master_read_addr, i_inst_read_addr};

  for (genvar g = 0; g < 2; g++) begin : g_rd
    localparam logic [3:0] LAT_M1 = 4'((g == 0 ? P_INST_LATENCY : P_READ_LATENCY) - 1);
    port_state_t state;
    logic [3:0]  cnt;
    logic [31:0] addr_q, cur_addr, data_q;
    logic        ack_q, err_q, enter_ack;
    acc_kind_t   kind;

    // In IDLE the live inputs are the sample; afterwards only the captured copy is used.
    always_comb begin
      cur_addr  = (state == ST_IDLE) ? rd_addr_in[g] : addr_q;
      kind      = classify(cur_addr);
      enter_ack = (state == ST_IDLE && rd_stb[g] && LAT_M1 == 4'd0) ||
                  (state == ST_WAIT && cnt == 4'd1);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        state  <= ST_IDLE;
        cnt    <= 4'd0;
        addr_q <= 32'd0;
        ack_q  <= 1'b0;
        err_q  <= 1'b0;
        data_q <= 32'd0;
      end else begin
        case (state)
          ST_IDLE: if (rd_stb[g]) begin
            addr_q <= rd_addr_in[g];
            cnt    <= LAT_M1;
            state  <= (LAT_M1 == 4'd0) ? ST_ACK : ST_WAIT;
          end
          ST_WAIT: begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= ST_ACK;
          end
          default: state <= ST_IDLE;
        endcase
        ack_q  <= enter_ack && kind != AC_OOR;
        err_q  <= enter_ack && kind == AC_OOR;
        data_q <= (enter_ack && kind == AC_MEM) ? mem_word(cur_addr) : 32'd0;
      end
    end
  end

  assign o_inst_read_ack    = g_rd[0].ack_q;
  assign o_inst_read_err    = g_rd[0].err_q;
  assign o_inst_read_data   = g_rd[0].data_q;
  assign o_master_read_ack  = g_rd[1].ack_q;
  assign o_master_read_err  = g_rd[1].err_q;
  assign o_master_read_data = g_rd[1].data_q;

  localparam logic [3:0] WR_LAT_M1 = 4'(P_WRITE_LATENCY - 1);
  port_state_t wr_state;
  logic [3:0]  wr_cnt, wr_sel_q, wr_sel;
  logic [31:0] wr_addr_q, wr_data_q, wr_addr, wr_data;
  logic        wr_enter_ack, wr_commit;
  acc_kind_t   wr_kind;

  always_comb begin
    if (wr_state == ST_IDLE) begin
      wr_addr = i_master_write_addr;
      wr_data = i_master_write_data;
      wr_sel  = i_master_write_sel;
    end else begin
      wr_addr = wr_addr_q;
      wr_data = wr_data_q;
      wr_sel  = wr_sel_q;
    end
    wr_kind      = classify(wr_addr);
    wr_enter_ack = (wr_state == ST_IDLE && i_master_write_stb && WR_LAT_M1 == 4'd0) ||
                   (wr_state == ST_WAIT && wr_cnt == 4'd1);
    wr_commit    = wr_enter_ack && wr_kind == AC_MEM;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_state           <= ST_IDLE;
      wr_cnt             <= 4'd0;
      wr_addr_q          <= 32'd0;
      wr_data_q          <= 32'd0;
      wr_sel_q           <= 4'd0;
      o_master_write_ack <= 1'b0;
      o_master_write_err <= 1'b0;
      o_console_valid    <= 1'b0;
      o_console_char     <= 8'd0;
      o_halt             <= 1'b0;
      o_halt_code        <= 32'd0;
    end else begin
      case (wr_state)
        ST_IDLE: if (i_master_write_stb) begin
          wr_addr_q <= i_master_write_addr;
          wr_data_q <= i_master_write_data;
          wr_sel_q  <= i_master_write_sel;
          wr_cnt    <= WR_LAT_M1;
          wr_state  <= (WR_LAT_M1 == 4'd0) ? ST_ACK : ST_WAIT;
        end
        ST_WAIT: begin
          wr_cnt <= wr_cnt - 4'd1;
          if (wr_cnt == 4'd1) wr_state <= ST_ACK;
        end
        default: wr_state <= ST_IDLE;
      endcase
      o_master_write_ack <= wr_enter_ack && wr_kind != AC_OOR;
      o_master_write_err <= wr_enter_ack && wr_kind == AC_OOR;
      o_console_valid    <= wr_enter_ack && wr_kind == AC_CONSOLE;
      if (wr_enter_ack && wr_kind == AC_CONSOLE) o_console_char <= wr_data[7:0];
      if (wr_enter_ack && wr_kind == AC_HALT) begin
        o_halt      <= 1'b1;
        o_halt_code <= wr_data;
      end
    end
  end

  // Memory has no reset; the reset gate only suppresses a commit from a discarded request.
  always_ff @(posedge i_clk) begin
    if (i_reset_n && wr_commit) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_sel[k]) mem[byte_idx(wr_addr, k)] <= wr_data[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_mem_model_mp.sv
// Randomised self-checking bench for wb_mem_model_mp against a byte-array reference model.
module tb_wb_mem_model_mp;
  localparam int LI = 1, LR = 4, LW = 5;
  localparam int MEM_BYTES = 262144;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_inst_read_stb, i_master_read_stb, i_master_write_stb;
  logic [31:0] i_inst_read_addr, i_master_read_addr, i_master_write_addr, i_master_write_data;
  logic [3:0]  i_master_write_sel;
  logic        o_inst_read_ack, o_inst_read_err, o_master_read_ack, o_master_read_err;
  logic        o_master_write_ack, o_master_write_err, o_console_valid, o_halt;
  logic [31:0] o_inst_read_data, o_master_read_data, o_halt_code;
  logic [7:0]  o_console_char;

  int checks = 0, passed = 0;
  logic [7:0] ref_mem [int];

  wb_mem_model_mp #(
    .P_MEM_BYTES(MEM_BYTES), .P_INST_LATENCY(LI), .P_READ_LATENCY(LR), .P_WRITE_LATENCY(LW)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_inst_read_stb(i_inst_read_stb), .o_inst_read_ack(o_inst_read_ack),
    .o_inst_read_err(o_inst_read_err), .i_inst_read_addr(i_inst_read_addr),
    .o_inst_read_data(o_inst_read_data),
    .i_master_read_stb(i_master_read_stb), .o_master_read_ack(o_master_read_ack),
    .o_master_read_err(o_master_read_err), .i_master_read_addr(i_master_read_addr),
    .o_master_read_data(o_master_read_data),
    .i_master_write_stb(i_master_write_stb), .o_master_write_ack(o_master_write_ack),
    .o_master_write_err(o_master_write_err), .i_master_write_addr(i_master_write_addr),
    .i_master_write_data(i_master_write_data), .i_master_write_sel(i_master_write_sel),
    .o_console_valid(o_console_valid), .o_console_char(o_console_char),
    .o_halt(o_halt), .o_halt_code(o_halt_code)
  );

  always #5 clk = ~clk;

  // 0 = memory, 1 = console, 2 = halt, 3 = out of range
  function automatic int kind(input logic [31:0] a);
    logic [31:0] eff;
    eff = a & ~32'h3;
    if (eff == 32'h1000_0000) return 1;
    if (eff == 32'h1000_0004) return 2;
    if (eff >= 32'(MEM_BYTES)) return 3;
    return 0;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [31:0] w;
    int eff;
    w = 32'd0;
    eff = int'(a & ~32'h3);
    if (kind(a) != 0) return 32'd0;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_mem.exists(eff + k) ? ref_mem[eff + k] : 8'h00;
    return w;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int eff;
    eff = int'(a & ~32'h3);
    if (kind(a) != 0) return;
    for (int k = 0; k < 4; k++) if (s[k]) ref_mem[eff + k] = d[8*k +: 8];
  endfunction

  task automatic rd(input int p, input logic [31:0] a, output logic [31:0] d, output logic e, output int cyc);
    logic ak, er;
    logic [31:0] dt;
    bit done;
    done = 0; d = 32'd0; e = 1'b0; cyc = 0; dt = 32'd0;
    if (p == 0) begin i_inst_read_addr = a; i_inst_read_stb = 1'b1; end
    else begin i_master_read_addr = a; i_master_read_stb = 1'b1; end
    while (!done && cyc < 40) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      ak = (p == 0) ? o_inst_read_ack : o_master_read_ack;
      er = (p == 0) ? o_inst_read_err : o_master_read_err;
      dt = (p == 0) ? o_inst_read_data : o_master_read_data;
      if (ak || er) begin
        done = 1; d = dt; e = er;
      end else begin
        checks++;
        if (dt !== 32'd0) $display("FAIL rd_wait_data port%0d addr=%h: got %h, want 0", p, a, dt);
        else passed++;
      end
    end
    if (p == 0) i_inst_read_stb = 1'b0; else i_master_read_stb = 1'b0;
    checks++;
    if (!done) $display("FAIL rd_timeout port%0d addr=%h: no ack/err in %0d edges", p, a, cyc);
    else passed++;
    @(posedge clk); #1;
    ak = (p == 0) ? o_inst_read_ack : o_master_read_ack;
    dt = (p == 0) ? o_inst_read_data : o_master_read_data;
    checks++;
    if (ak !== 1'b0 || dt !== 32'd0) $display("FAIL rd_pulse port%0d: ack=%b data=%h after ack, want 0/0", p, ak, dt);
    else passed++;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output logic e,
                    output int cyc, output logic cv, output logic [7:0] cc, output logic hv, output logic [31:0] hc);
    bit done;
    done = 0; e = 1'b0; cyc = 0; cv = 1'b0; cc = 8'd0; hv = 1'b0; hc = 32'd0;
    i_master_write_addr = a; i_master_write_data = d; i_master_write_sel = s; i_master_write_stb = 1'b1;
    while (!done && cyc < 40) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (o_master_write_ack || o_master_write_err) begin
        done = 1; e = o_master_write_err; cv = o_console_valid; cc = o_console_char;
        hv = o_halt; hc = o_halt_code;
      end
    end
    i_master_write_stb = 1'b0;
    checks++;
    if (!done) $display("FAIL wr_timeout addr=%h: no ack/err in %0d edges", a, cyc);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (o_master_write_ack !== 1'b0 || o_console_valid !== 1'b0)
      $display("FAIL wr_pulse: ack=%b console_valid=%b after ack, want 0/0", o_master_write_ack, o_console_valid);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_inst_read_stb = 0; i_master_read_stb = 0; i_master_write_stb = 0;
    i_inst_read_addr = 0; i_master_read_addr = 0; i_master_write_addr = 0;
    i_master_write_data = 0; i_master_write_sel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({o_inst_read_ack, o_inst_read_err, o_master_read_ack, o_master_read_err,
         o_master_write_ack, o_master_write_err} !== 6'b0)
      $display("FAIL reset_handshake: ack/err bits=%b, want 000000", {o_inst_read_ack, o_inst_read_err,
               o_master_read_ack, o_master_read_err, o_master_write_ack, o_master_write_err});
    else passed++;
    checks++;
    if (o_inst_read_data !== 32'd0 || o_master_read_data !== 32'd0)
      $display("FAIL reset_data: inst=%h data=%h, want 0/0", o_inst_read_data, o_master_read_data);
    else passed++;
    checks++;
    if (o_console_valid !== 1'b0 || o_console_char !== 8'd0)
      $display("FAIL reset_console: valid=%b char=%h, want 0/00", o_console_valid, o_console_char);
    else passed++;
    checks++;
    if (o_halt !== 1'b0 || o_halt_code !== 32'd0)
      $display("FAIL reset_halt: halt=%b code=%h, want 0/0", o_halt, o_halt_code);
    else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_inst_fetch();
    logic e, cv, hv, ea;
    logic [7:0] cc;
    logic [31:0] hc, d, w;
    int cyc;
    w = 32'h9300_0013;
    wr(32'h0001_0000, w, 4'hF, e, cyc, cv, cc, hv, hc);
    model_write(32'h0001_0000, w, 4'hF);
    checks++;
    if (e !== 1'b0 || cyc != LW) $display("FAIL fetch_setup_write: err=%b edges=%0d, want 0/%0d", e, cyc, LW);
    else passed++;
    rd(0, 32'h0001_0000, d, e, cyc);
    checks++;
    if (d !== model_word(32'h0001_0000) || e !== 1'b0 || cyc != LI)
      $display("FAIL fetch_single: data=%h err=%b edges=%0d, want %h/0/%0d", d, e, cyc, model_word(32'h0001_0000), LI);
    else passed++;
    i_inst_read_addr = 32'h0001_0000; i_inst_read_stb = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); @(negedge clk);
      ea = (k % 2 == 1);
      checks++;
      if (o_inst_read_ack !== ea || o_inst_read_data !== (ea ? w : 32'd0))
        $display("FAIL fetch_held edge%0d: ack=%b data=%h, want %b/%h", k, o_inst_read_ack, o_inst_read_data, ea, ea ? w : 32'd0);
      else passed++;
    end
    i_inst_read_stb = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_read_latency();
    logic e, cv, hv;
    logic [7:0] cc;
    logic [31:0] hc, d, w;
    int cyc;
    repeat (2) begin
      w = $urandom;
      wr(32'h0000_2000, w, 4'hF, e, cyc, cv, cc, hv, hc);
      model_write(32'h0000_2000, w, 4'hF);
      rd(1, 32'h0000_2000, d, e, cyc);
      checks++;
      if (d !== model_word(32'h0000_2000) || e !== 1'b0 || cyc != LR)
        $display("FAIL read_latency: data=%h err=%b edges=%0d, want %h/0/%0d", d, e, cyc, model_word(32'h2000), LR);
      else passed++;
    end
  endtask

  task automatic test_byte_enable();
    logic e, cv, hv;
    logic [7:0] cc;
    logic [31:0] hc, d, a;
    int cyc;
    for (int i = 0; i < 2; i++) begin
      a = (i == 0) ? 32'h0000_0100 : 32'h0000_0103;
      wr(32'h0000_0100, 32'd0, 4'hF, e, cyc, cv, cc, hv, hc);
      model_write(32'h0000_0100, 32'd0, 4'hF);
      wr(a, 32'hAABB_CCDD, 4'b0101, e, cyc, cv, cc, hv, hc);
      model_write(a, 32'hAABB_CCDD, 4'b0101);
      rd(1, 32'h0000_0100, d, e, cyc);
      checks++;
      if (d !== 32'h00BB_00DD || d !== model_word(32'h100))
        $display("FAIL byte_enable addr=%h: got %h, want 00bb00dd", a, d);
      else passed++;
    end
    wr(32'h0000_0100, 32'hFFFF_FFFF, 4'b0000, e, cyc, cv, cc, hv, hc);
    checks++;
    if (e !== 1'b0 || cyc != LW) $display("FAIL sel_zero_ack: err=%b edges=%0d, want 0/%0d", e, cyc, LW);
    else passed++;
    rd(0, 32'h0000_0100, d, e, cyc);
    checks++;
    if (d !== 32'h00BB_00DD) $display("FAIL sel_zero_nochange: got %h, want 00bb00dd", d);
    else passed++;
  endtask

  task automatic test_mmio();
    logic e, cv, hv;
    logic [7:0] cc;
    logic [31:0] hc, d;
    int cyc;
    wr(32'h1000_0000, 32'hFFFF_FF41, 4'b0000, e, cyc, cv, cc, hv, hc);
    checks++;
    if (e !== 1'b0 || cv !== 1'b1 || cc !== 8'h41 || cyc != LW)
      $display("FAIL console_write: err=%b valid=%b char=%h edges=%0d, want 0/1/41/%0d", e, cv, cc, cyc, LW);
    else passed++;
    checks++;
    if (o_console_char !== 8'h41) $display("FAIL console_hold: char=%h, want 41", o_console_char);
    else passed++;
    rd(1, 32'h1000_0000, d, e, cyc);
    checks++;
    if (d !== 32'd0 || e !== 1'b0 || cyc != LR) $display("FAIL mmio_read_console: data=%h err=%b, want 0/0", d, e);
    else passed++;
    rd(0, 32'h1000_0006, d, e, cyc);
    checks++;
    if (d !== 32'd0 || e !== 1'b0) $display("FAIL mmio_read_halt: data=%h err=%b, want 0/0", d, e);
    else passed++;
    wr(32'h1000_0004, 32'h0000_002A, 4'hF, e, cyc, cv, cc, hv, hc);
    checks++;
    if (e !== 1'b0 || hv !== 1'b1 || hc !== 32'h2A || cv !== 1'b0)
      $display("FAIL halt_write: err=%b halt=%b code=%h console=%b, want 0/1/2a/0", e, hv, hc, cv);
    else passed++;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (o_halt !== 1'b1 || o_halt_code !== 32'h2A) $display("FAIL halt_sticky: halt=%b code=%h, want 1/2a", o_halt, o_halt_code);
    else passed++;
    wr(32'h1000_0007, 32'h0000_0007, 4'h1, e, cyc, cv, cc, hv, hc);
    checks++;
    if (o_halt !== 1'b1 || o_halt_code !== 32'h7) $display("FAIL halt_overwrite: halt=%b code=%h, want 1/7", o_halt, o_halt_code);
    else passed++;
  endtask

  task automatic test_error();
    logic e, cv, hv;
    logic [7:0] cc;
    logic [31:0] hc, d;
    int cyc;
    wr(32'h0000_0000, 32'h1234_5678, 4'hF, e, cyc, cv, cc, hv, hc);
    model_write(32'h0, 32'h1234_5678, 4'hF);
    wr(32'h0003_FFFC, 32'hDEAD_BEEF, 4'hF, e, cyc, cv, cc, hv, hc);
    model_write(32'h0003_FFFC, 32'hDEAD_BEEF, 4'hF);
    rd(1, 32'h0004_0000, d, e, cyc);
    checks++;
    if (e !== 1'b1 || d !== 32'd0 || cyc != LR) $display("FAIL err_read: err=%b data=%h edges=%0d, want 1/0/%0d", e, d, cyc, LR);
    else passed++;
    rd(0, 32'h0FFF_FFFC, d, e, cyc);
    checks++;
    if (e !== 1'b1 || d !== 32'd0 || cyc != LI) $display("FAIL err_inst: err=%b data=%h edges=%0d, want 1/0/%0d", e, d, cyc, LI);
    else passed++;
    wr(32'h0004_0000, 32'hFFFF_FFFF, 4'hF, e, cyc, cv, cc, hv, hc);
    checks++;
    if (e !== 1'b1 || cyc != LW) $display("FAIL err_write: err=%b edges=%0d, want 1/%0d", e, cyc, LW);
    else passed++;
    rd(1, 32'h0000_0000, d, e, cyc);
    checks++;
    if (d !== model_word(32'h0) || e !== 1'b0) $display("FAIL err_no_alias: data=%h, want %h", d, model_word(32'h0));
    else passed++;
    rd(1, 32'h0003_FFFF, d, e, cyc);
    checks++;
    if (d !== model_word(32'h0003_FFFC) || e !== 1'b0) $display("FAIL last_word: data=%h err=%b, want %h/0", d, e, model_word(32'h3FFFC));
    else passed++;
  endtask

  task automatic test_same_edge();
    logic e, ew, er, ei, cv, hv;
    logic [7:0] cc;
    logic [31:0] hc, d, di, old;
    int cyc, cw, cr;
    wr(32'h0000_0200, 32'h1122_3344, 4'hF, e, cyc, cv, cc, hv, hc);
    model_write(32'h200, 32'h1122_3344, 4'hF);
    old = model_word(32'h200);
    fork
      wr(32'h0000_0200, 32'h0000_0055, 4'hF, ew, cw, cv, cc, hv, hc);
      begin @(posedge clk); #1; rd(1, 32'h0000_0200, d, er, cr); end
    join
    model_write(32'h200, 32'h55, 4'hF);
    checks++;
    if (d !== old || cw != LW || cr != LR)
      $display("FAIL same_edge_old: data=%h wr_edges=%0d rd_edges=%0d, want %h/%0d/%0d", d, cw, cr, old, LW, LR);
    else passed++;
    fork
      rd(0, 32'h0000_0200, di, ei, cyc);
      rd(1, 32'h0000_0202, d, er, cr);
    join
    checks++;
    if (d !== 32'h55 || di !== 32'h55 || er !== 1'b0 || ei !== 1'b0)
      $display("FAIL same_edge_new: data=%h inst=%h, want 00000055/00000055", d, di);
    else passed++;
  endtask

  task automatic test_random();
    logic e, cv, hv;
    logic [7:0] cc;
    logic [31:0] hc, d, a, w;
    logic [3:0] s;
    int cyc, op, p;
    for (int i = 0; i < 64; i++) begin
      a = 32'h3000 + 32'(i * 4); w = $urandom;
      wr(a, w, 4'hF, e, cyc, cv, cc, hv, hc);
      model_write(a, w, 4'hF);
    end
    repeat (80) begin
      op = $urandom_range(0, 3);
      a = 32'h3000 + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
      if (op == 0) begin
        w = $urandom; s = 4'($urandom_range(0, 15));
        wr(a, w, s, e, cyc, cv, cc, hv, hc);
        model_write(a, w, s);
        checks++;
        if (e !== 1'b0 || cyc != LW || cv !== 1'b0) $display("FAIL rand_write addr=%h: err=%b edges=%0d", a, e, cyc);
        else passed++;
      end else if (op == 3) begin
        p = $urandom_range(0, 1);
        a = 32'h0004_0000 + 32'($urandom_range(0, 1023) * 4);
        rd(p, a, d, e, cyc);
        checks++;
        if (e !== 1'b1 || d !== 32'd0 || cyc != (p == 0 ? LI : LR))
          $display("FAIL rand_oor port%0d addr=%h: err=%b data=%h edges=%0d", p, a, e, d, cyc);
        else passed++;
      end else begin
        p = (op == 1) ? 1 : 0;
        rd(p, a, d, e, cyc);
        checks++;
        if (d !== model_word(a) || e !== 1'b0 || cyc != (p == 0 ? LI : LR))
          $display("FAIL rand_read port%0d addr=%h: data=%h err=%b edges=%0d, want %h", p, a, d, e, cyc, model_word(a));
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic e, cv, hv;
    logic [7:0] cc;
    logic [31:0] hc, d;
    int cyc, seen;
    seen = 0;
    wr(32'h0000_0300, 32'hCAFE_F00D, 4'hF, e, cyc, cv, cc, hv, hc);
    model_write(32'h300, 32'hCAFE_F00D, 4'hF);
    i_master_write_addr = 32'h300; i_master_write_data = 32'h1234_5678; i_master_write_sel = 4'hF;
    i_master_write_stb = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0; i_master_write_stb = 1'b0;
    #1;
    checks++;
    if (o_halt !== 1'b0 || o_halt_code !== 32'd0) $display("FAIL reset_mid_halt: halt=%b code=%h, want 0/0", o_halt, o_halt_code);
    else passed++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (o_master_write_ack || o_master_write_err) seen++;
    end
    checks++;
    if (seen != 0) $display("FAIL reset_mid_no_ack: saw %0d ack/err cycles, want 0", seen);
    else passed++;
    @(posedge clk); #1;
    rd(1, 32'h0000_0300, d, e, cyc);
    checks++;
    if (d !== model_word(32'h300) || e !== 1'b0) $display("FAIL reset_mid_mem: data=%h, want %h", d, model_word(32'h300));
    else passed++;
  endtask

  initial begin
    test_reset();
    test_inst_fetch();
    test_read_latency();
    test_byte_enable();
    test_mmio();
    test_error();
    test_same_edge();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
